// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix BRAM loader: FSM state encoding,
// default geometry and the start-time dimension check.
package matrix_pkg;

  localparam int DEF_ROWS       = 5;
  localparam int DEF_COLS       = 5;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_ROWS * DEF_COLS);
  localparam int DEF_DIM_WIDTH  = $clog2(((DEF_ROWS > DEF_COLS) ? DEF_ROWS : DEF_COLS) + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    FIN  = 2'd3
  } loader_state_e;

  function automatic logic dims_valid(input int rows, input int cols,
                                      input int max_rows, input int max_cols);
    return (rows >= 1) && (rows <= max_rows) && (cols >= 1) && (cols <= max_cols);
  endfunction

endpackage

// File: rtl/matrix_addr_counter.sv
// Row/column walker over a lim_rows x lim_cols window with a fixed address stride.
// The address is row-base + c so no multiplier is needed; the last step wraps to 0.
module matrix_addr_counter
  import matrix_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
  parameter int STRIDE     = DEF_COLS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  step,
  input  logic [DIM_WIDTH-1:0]  lim_rows,
  input  logic [DIM_WIDTH-1:0]  lim_cols,
  output logic [DIM_WIDTH-1:0]  r,
  output logic [DIM_WIDTH-1:0]  c,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [DIM_WIDTH-1:0]  r_q, r_d, c_q, c_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  row_end;

  assign row_end = (c_q == lim_cols - DIM_WIDTH'(1));
  assign last    = row_end && (r_q == lim_rows - DIM_WIDTH'(1));
  assign r       = r_q;
  assign c       = c_q;
  assign addr    = base_q + ADDR_WIDTH'(c_q);

  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    base_d = base_q;
    // Wrapping to 0 on the last cell keeps base from ever stepping past the array.
    if (clear || (step && last)) begin
      r_d    = '0;
      c_d    = '0;
      base_d = '0;
    end else if (step) begin
      if (row_end) begin
        c_d    = '0;
        r_d    = r_q + DIM_WIDTH'(1);
        base_d = base_q + ADDR_WIDTH'(STRIDE);
      end else begin
        c_d = c_q + DIM_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      c_q    <= '0;
      base_q <= '0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/matrix_bram_loader.sv
// Streams a cfg_rows x cfg_cols row-major matrix into the top-left of a ROWS x COLS
// BRAM, optionally zero-filling every cell outside that region afterwards.
module matrix_bram_loader
  import matrix_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int ADDR_WIDTH = $clog2(ROWS * COLS),
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1),
  parameter int ZERO_FILL  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [DIM_WIDTH-1:0] ROWS_L = DIM_WIDTH'(ROWS);
  localparam logic [DIM_WIDTH-1:0] COLS_L = DIM_WIDTH'(COLS);

  loader_state_e         state_q, state_d;
  logic [DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic                  ready_q, wr_en_q, wr_en_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic                  ld_clear, ld_step, ld_last;
  logic [DIM_WIDTH-1:0]  ld_r, ld_c;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  fl_clear, fl_step, fl_last;
  logic [DIM_WIDTH-1:0]  fl_r, fl_c;
  logic [ADDR_WIDTH-1:0] fl_addr;
  logic                  unused_ld;

  assign unused_ld = ^{ld_r, ld_c};

  matrix_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH), .STRIDE(COLS)
  ) u_load_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ld_clear),
    .step     (ld_step),
    .lim_rows (rows_q),
    .lim_cols (cols_q),
    .r        (ld_r),
    .c        (ld_c),
    .addr     (ld_addr),
    .last     (ld_last)
  );

  matrix_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH), .STRIDE(COLS)
  ) u_fill_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (fl_clear),
    .step     (fl_step),
    .lim_rows (ROWS_L),
    .lim_cols (COLS_L),
    .r        (fl_r),
    .c        (fl_c),
    .addr     (fl_addr),
    .last     (fl_last)
  );

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    ld_clear = 1'b0;
    ld_step  = 1'b0;
    fl_clear = 1'b0;
    fl_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_valid(int'(cfg_rows), int'(cfg_cols), ROWS, COLS)) begin
            rows_d   = cfg_rows;
            cols_d   = cfg_cols;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            ld_clear = 1'b1;
            fl_clear = 1'b1;
            state_d  = LOAD;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // ready_q mirrors state_q == LOAD, so s_valid alone is the handshake here.
        if (s_valid) begin
          wr_en_d = 1'b1;
          addr_d  = ld_addr;
          din_d   = s_data;
          ld_step = 1'b1;
          if (ld_last) state_d = (ZERO_FILL != 0) ? FILL : FIN;
        end
      end
      FILL: begin
        fl_step = 1'b1;
        wr_en_d = (fl_r >= rows_q) || (fl_c >= cols_q);
        addr_d  = fl_addr;
        din_d   = '0;
        if (fl_last) state_d = FIN;
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      ready_q <= (state_d == LOAD);
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_ready    = ready_q;
  assign bram_wr_en = wr_en_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_matrix_bram_loader.sv
// Directed/randomized bench for matrix_bram_loader: a queue-based reference of the
// expected write sequence plus a downstream BRAM image checked cell by cell.
module tb_matrix_bram_loader;

  localparam int R = 5;
  localparam int C = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cfg_rows = '0, cfg_cols = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, bram_wr_en, busy, done, err;
  logic [4:0]  bram_addr;
  logic [31:0] bram_din;

  int checks = 0;
  int failures = 0;

  matrix_bram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .bram_wr_en(bram_wr_en),
    .bram_addr(bram_addr), .bram_din(bram_din), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Downstream observer: BRAM image, write log, done pulses.
  int          cyc = 0;
  int unsigned obs_addr[$];
  int unsigned obs_data[$];
  int unsigned mem[R*C];
  int          done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, bad_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_wr_en) begin
      obs_addr.push_back(int'(bram_addr));
      obs_data.push_back(bram_din);
      last_wr_cyc = cyc;
      if (int'(bram_addr) >= R*C) bad_addr++;
      else mem[bram_addr] = bram_din;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_wr_en"}, bram_wr_en, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_din"}, bram_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Drive n beats with s_valid asserted pct% of cycles; optionally pulse a spurious
  // start (2x2) when beat glitch_at is being presented.
  task automatic stream(input int unsigned d[$], input int pct, input int glitch_at);
    int i = 0;
    int guard = 0;
    bit glitched = 0;
    while (i < d.size() && guard < 2000) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (i == glitch_at && !glitched) begin
        glitched = 1;
        start = 1'b1;
        cfg_rows = 3'd2;
        cfg_cols = 3'd2;
      end
      s_valid = ($urandom_range(99) < pct);
      s_data  = d[i];
      if (s_valid && s_ready) i++;
    end
    chk("stream_bound", guard < 2000, 1);
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input int rows, input int cols, input int pct,
                          input bit rnd, input int glitch_at, input int exp_done_gap);
    int unsigned d[$];
    int unsigned exp_a[$];
    int unsigned exp_d[$];
    int base, dbase, k, wait_n, rdy_bad;
    for (int i = 0; i < rows*cols; i++) d.push_back(rnd ? $urandom : i + 1);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        exp_a.push_back(r*C + c);
        exp_d.push_back(d[r*cols + c]);
      end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (r >= rows || c >= cols) begin
          exp_a.push_back(r*C + c);
          exp_d.push_back(0);
        end
    base  = obs_addr.size();
    dbase = done_cnt;
    @(negedge clk);
    chk({tag, "_ready_idle"}, s_ready, 0);
    start = 1'b1;
    cfg_rows = 3'(rows);
    cfg_cols = 3'(cols);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    stream(d, pct, glitch_at);
    // Hold junk on s_valid: it must never be taken once the last beat is in.
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    wait_n  = 0;
    rdy_bad = 0;
    while (done_cnt == dbase && wait_n < 300) begin
      if (s_ready) rdy_bad++;
      @(negedge clk);
      wait_n++;
    end
    s_valid = 1'b0;
    chk({tag, "_done_seen"}, wait_n < 300, 1);
    chk({tag, "_ready_low_after_load"}, rdy_bad, 0);
    chk({tag, "_err"}, err, 0);
    if (exp_done_gap > 0) chk({tag, "_done_gap"}, done_cyc - last_wr_cyc, exp_done_gap);
    @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - dbase, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_ready_end"}, s_ready, 0);
    chk({tag, "_bad_addr"}, bad_addr, 0);
    chk({tag, "_nwrites"}, obs_addr.size() - base, exp_a.size());
    k = 0;
    for (int i = base; i < obs_addr.size() && k < exp_a.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, k), obs_addr[i], exp_a[k]);
      chk($sformatf("%s_wr%0d_data", tag, k), obs_data[i], exp_d[k]);
      k++;
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        chk($sformatf("%s_mem%0d", tag, r*C + c), mem[r*C + c],
            (r < rows && c < cols) ? d[r*cols + c] : 0);
  endtask

  task automatic bad_start(input string tag, input int rows, input int cols);
    int base;
    base = obs_addr.size();
    @(negedge clk);
    start = 1'b1;
    cfg_rows = 3'(rows);
    cfg_cols = 3'(cols);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_err_held"}, err, 1);
    chk({tag, "_busy_after"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_no_writes"}, obs_addr.size() - base, 0);
  endtask

  initial begin
    for (int i = 0; i < R*C; i++) mem[i] = 32'hBAD0_BAD0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    run_load("t1_3x2", 3, 2, 100, 0, -1, 0);
    run_load("t2_3x2_gaps", 3, 2, 50, 1, -1, 0);
    bad_start("t3_6x1", 6, 1);
    bad_start("t3_0x3", 0, 3);
    run_load("t4_5x5", 5, 5, 100, 1, -1, 26);
    run_load("t_1x1", 1, 1, 70, 1, -1, 0);

    // Abandon a 3x3 load after three beats with an asynchronous reset.
    begin
      int unsigned d3[$];
      d3 = '{32'hA1, 32'hA2, 32'hA3};
      @(negedge clk);
      start = 1'b1;
      cfg_rows = 3'd3;
      cfg_cols = 3'd3;
      @(negedge clk);
      start = 1'b0;
      stream(d3, 100, -1);
      chk("t5_busy_before_rst", busy, 1);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("t5_async_rst");
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_load("t5_2x2_after_rst", 2, 2, 100, 0, -1, 0);

    run_load("t6_ignore_start", 3, 4, 80, 1, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
